// File: rtl/io_cfg_loader_pkg.sv
// rtl/io_cfg_loader_pkg.sv - shared types, CRC constants and CRC step function for io_cfg_loader
package io_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } io_cfg_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One bit-serial CRC-16-CCITT step, message bit taken MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/io_cfg_loader_if.sv
// rtl/io_cfg_loader_if.sv - host handshake and scan-chain signal bundle for io_cfg_loader
interface io_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              config_en;
  logic              config_data_in;
  logic              config_data_out;
  logic              busy;
  logic              done;
  logic              error;

  // Environment side: host plus the scan chain's serial output.
  modport master (
    output start, abort, word_in, word_valid, config_data_out,
    input  word_ready, config_en, config_data_in, busy, done, error
  );

  // Loader side.
  modport slave (
    input  start, abort, word_in, word_valid, config_data_out,
    output word_ready, config_en, config_data_in, busy, done, error
  );
endinterface

// File: rtl/io_cfg_loader_crc16.sv
// rtl/io_cfg_loader_crc16.sv - bit-serial CRC-16-CCITT accumulator (crc16_serial)
module crc16_serial
  import io_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  // Accumulate one bit per enabled cycle; clear takes precedence.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/io_cfg_loader.sv
// rtl/io_cfg_loader.sv - IO ring CRAM chain loader; optional readback verify under IO_CFG_READBACK_EN
module io_cfg_loader
  import io_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 384,
  parameter int WORD_W    = 8
) (
  input  logic           clk,
  input  logic           nrst,
  io_cfg_loader_if.slave bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  if (CHAIN_LEN == 0 || (CHAIN_LEN % WORD_W) != 0) begin : g_bad_chain_len
    $error("io_cfg_loader: CHAIN_LEN must be a nonzero multiple of WORD_W");
  end

  io_cfg_state_t     state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [WB_W-1:0]   wbit_cnt_q;
  logic [WORD_W-1:0] shreg_q;

`ifdef IO_CFG_READBACK_EN
  logic        error_q;
  logic [15:0] load_crc;
  logic [15:0] rb_crc;

  crc16_serial u_load_crc (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (state_q == ST_IDLE),
    .en     (state_q == ST_SHIFT),
    .bit_in (shreg_q[WORD_W-1]),
    .crc    (load_crc)
  );

  crc16_serial u_rb_crc (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (state_q == ST_IDLE),
    .en     (state_q == ST_VERIFY),
    .bit_in (bus.config_data_out),
    .crc    (rb_crc)
  );

  assign bus.error          = error_q;
  // During verify the chain recirculates so its contents survive the readback.
  assign bus.config_data_in = (state_q == ST_SHIFT)  ? shreg_q[WORD_W-1] :
                              (state_q == ST_VERIFY) ? bus.config_data_out : 1'b0;
`else
  logic unused_config_data_out;
  assign unused_config_data_out = bus.config_data_out;
  assign bus.error              = 1'b0;
  assign bus.config_data_in     = (state_q == ST_SHIFT) & shreg_q[WORD_W-1];
`endif

  assign bus.word_ready = (state_q == ST_FETCH);
  assign bus.config_en  = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);

  // Load sequencer: fetch a word, shift it out MSB first, repeat until the chain is full.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wbit_cnt_q <= '0;
      shreg_q    <= '0;
`ifdef IO_CFG_READBACK_EN
      error_q    <= 1'b0;
`endif
    end else if (bus.abort) begin
      // Abort wins over start, handshake and completion; the partial load stays in the chain.
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q  <= '0;
          wbit_cnt_q <= '0;
          if (bus.start) begin
            state_q <= ST_FETCH;
`ifdef IO_CFG_READBACK_EN
            error_q <= 1'b0;
`endif
          end
        end
        ST_FETCH: begin
          if (bus.word_valid) begin
            shreg_q <= bus.word_in;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (wbit_cnt_q == WB_W'(WORD_W - 1)) begin
            wbit_cnt_q <= '0;
            if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
`ifdef IO_CFG_READBACK_EN
              state_q   <= ST_VERIFY;
              bit_cnt_q <= '0;
`else
              state_q   <= ST_DONE;
`endif
            end else begin
              state_q <= ST_FETCH;
            end
          end else begin
            wbit_cnt_q <= wbit_cnt_q + WB_W'(1);
          end
        end
`ifdef IO_CFG_READBACK_EN
        ST_VERIFY: begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            state_q <= ST_DONE;
            // Fold in the final readback bit so the flag lands together with done.
            error_q <= (crc16_step(rb_crc, bus.config_data_out) != load_crc);
          end
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_cfg_loader.sv
// tb/tb_io_cfg_loader.sv - directed self-checking bench for io_cfg_loader with a behavioural scan chain
module tb_io_cfg_loader;

`ifdef IO_CFG_READBACK_EN
  localparam int VLAT = 384;
`else
  localparam int VLAT = 0;
`endif
  localparam int LAT = 432 + VLAT;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic stuck = 1'b0;
  logic chain_clr = 1'b1;
  logic [383:0] chain;
  logic [383:0] exp_chain;

  int pass_cnt = 0;
  int total_cnt = 0;

  int r_en, r_hs, r_done, r_lat, r_stall_bad, r_guard;
  logic r_first_ok, r_ab_en, r_ab_busy, r_err_first;

  io_cfg_loader_if #(.WORD_W(8)) bus ();

  io_cfg_loader #(.CHAIN_LEN(384), .WORD_W(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural CRAM chain: shifts toward bit 383, optional stuck-at-1 at stage 100.
  always @(posedge clk) begin
    logic [383:0] t;
    if (chain_clr) begin
      chain <= '0;
    end else if (bus.config_en) begin
      t = {chain[382:0], bus.config_data_in};
      if (stuck) t[100] = 1'b1;
      chain <= t;
    end
  end
  assign bus.config_data_out = chain[383];

  task automatic clear_chain();
    @(negedge clk);
    chain_clr = 1'b1;
    @(negedge clk);
    chain_clr = 1'b0;
  endtask

  task automatic run_load(input bit stall, input int abort_at, input int start_at);
    int idx, stall_left, cyc, guard;
    bit ab_prev, ab_used, stalled_prev;
    idx = 0; stall_left = 0; cyc = -1; ab_prev = 0; ab_used = 0; stalled_prev = 0;
    r_en = 0; r_hs = 0; r_done = 0; r_lat = -1; r_stall_bad = 0;
    r_ab_en = 1'b1; r_ab_busy = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    r_first_ok  = bus.busy && bus.word_ready;
    r_err_first = bus.error;
    for (guard = 0; guard < 4000; guard++) begin
      if (bus.word_ready && cyc < 0) cyc = 0;
      if (bus.config_en) r_en++;
      if (bus.done) begin
        r_done++;
        r_lat = cyc;
      end
      if (stalled_prev && bus.config_en) r_stall_bad++;
      if (ab_prev) begin
        r_ab_en   = bus.config_en;
        r_ab_busy = bus.busy;
      end
      if (cyc >= 0 && !bus.busy) break;
      bus.start = (start_at > 0 && cyc == start_at);
      stalled_prev = 0;
      if (stall && bus.word_ready && stall_left > 0) begin
        bus.word_valid = 1'b0;
        stall_left--;
        stalled_prev = 1;
      end else begin
        bus.word_valid = (idx < 48);
        bus.word_in    = 8'(idx);
      end
      if (bus.word_valid && bus.word_ready) begin
        r_hs++;
        idx++;
        if (stall && (idx % 3) == 2) stall_left = 5;
      end
      ab_prev = 0;
      if (!ab_used && abort_at > 0 && r_en == abort_at) begin
        ab_used = 1;
        ab_prev = 1;
      end
      bus.abort = ab_prev;
      if (cyc >= 0) cyc++;
      @(negedge clk);
    end
    r_guard = guard;
    bus.word_valid = 1'b0;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) r_done++;
    end
    total_cnt++;
    if (r_guard >= 4000) $display("FAIL load_timeout: cycles %0d limit 4000", r_guard);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus.word_ready, bus.config_en, bus.config_data_in, bus.busy, bus.done, bus.error} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.word_ready, bus.config_en, bus.config_data_in, bus.busy, bus.done, bus.error});
    else pass_cnt++;
    nrst = 1'b1;
    chain_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL idle_after_reset: busy %b expected 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    clear_chain();
    run_load(0, 0, 0);
    total_cnt++;
    if (r_first_ok !== 1'b1) $display("FAIL start_latency: busy&ready %b expected 1", r_first_ok);
    else pass_cnt++;
    total_cnt++;
    if (r_en != 384 + VLAT) $display("FAIL nominal_en_cycles: got %0d expected %0d", r_en, 384 + VLAT);
    else pass_cnt++;
    total_cnt++;
    if (r_hs != 48) $display("FAIL nominal_handshakes: got %0d expected 48", r_hs);
    else pass_cnt++;
    total_cnt++;
    if (r_done != 1) $display("FAIL nominal_done_count: got %0d expected 1", r_done);
    else pass_cnt++;
    total_cnt++;
    if (r_lat != LAT) $display("FAIL nominal_done_latency: got %0d expected %0d", r_lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (chain !== exp_chain) $display("FAIL nominal_chain: got %h expected %h", chain, exp_chain);
    else pass_cnt++;
    total_cnt++;
    if (bus.error !== 1'b0) $display("FAIL nominal_error: got %b expected 0", bus.error);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    clear_chain();
    run_load(1, 0, 0);
    total_cnt++;
    if (r_stall_bad != 0) $display("FAIL stall_config_en: shifting cycles during stall %0d expected 0", r_stall_bad);
    else pass_cnt++;
    total_cnt++;
    if (r_en != 384 + VLAT) $display("FAIL stall_en_cycles: got %0d expected %0d", r_en, 384 + VLAT);
    else pass_cnt++;
    total_cnt++;
    if (r_lat != LAT + 80) $display("FAIL stall_done_latency: got %0d expected %0d", r_lat, LAT + 80);
    else pass_cnt++;
    total_cnt++;
    if (r_done != 1) $display("FAIL stall_done_count: got %0d expected 1", r_done);
    else pass_cnt++;
    total_cnt++;
    if (chain !== exp_chain) $display("FAIL stall_chain: got %h expected %h", chain, exp_chain);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    clear_chain();
    run_load(0, 10, 0);
    total_cnt++;
    if (r_en != 10) $display("FAIL abort_en_cycles: got %0d expected 10", r_en);
    else pass_cnt++;
    total_cnt++;
    if (r_hs != 2) $display("FAIL abort_handshakes: got %0d expected 2", r_hs);
    else pass_cnt++;
    total_cnt++;
    if (r_ab_en !== 1'b0) $display("FAIL abort_config_en: got %b expected 0", r_ab_en);
    else pass_cnt++;
    total_cnt++;
    if (r_ab_busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", r_ab_busy);
    else pass_cnt++;
    total_cnt++;
    if (r_done != 0) $display("FAIL abort_no_done: got %0d expected 0", r_done);
    else pass_cnt++;
    run_load(0, 0, 0);
    total_cnt++;
    if (r_done != 1) $display("FAIL reload_done_count: got %0d expected 1", r_done);
    else pass_cnt++;
    total_cnt++;
    if (chain !== exp_chain) $display("FAIL reload_chain: got %h expected %h", chain, exp_chain);
    else pass_cnt++;
  endtask

  task automatic test_start_mid_load();
    clear_chain();
    run_load(0, 0, 100);
    total_cnt++;
    if (r_hs != 48) $display("FAIL midstart_handshakes: got %0d expected 48", r_hs);
    else pass_cnt++;
    total_cnt++;
    if (r_done != 1) $display("FAIL midstart_done_count: got %0d expected 1", r_done);
    else pass_cnt++;
    total_cnt++;
    if (r_lat != LAT) $display("FAIL midstart_done_latency: got %0d expected %0d", r_lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (chain !== exp_chain) $display("FAIL midstart_chain: got %h expected %h", chain, exp_chain);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.word_in = 8'hA5;
    bus.word_valid = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus.config_en, bus.busy} !== 2'b11) $display("FAIL pre_reset_shift: en,busy %b expected 11", {bus.config_en, bus.busy});
    else pass_cnt++;
    #2 nrst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.word_ready, bus.config_en, bus.config_data_in, bus.busy, bus.done, bus.error} !== 6'b0)
      $display("FAIL async_reset_outputs: got %b expected 000000",
               {bus.word_ready, bus.config_en, bus.config_data_in, bus.busy, bus.done, bus.error});
    else pass_cnt++;
    @(negedge clk);
    bus.word_valid = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
  endtask

`ifdef IO_CFG_READBACK_EN
  task automatic test_readback_stuck();
    clear_chain();
    stuck = 1'b1;
    run_load(0, 0, 0);
    total_cnt++;
    if (r_done != 1) $display("FAIL stuck_done_count: got %0d expected 1", r_done);
    else pass_cnt++;
    total_cnt++;
    if (bus.error !== 1'b1) $display("FAIL stuck_error: got %b expected 1", bus.error);
    else pass_cnt++;
    stuck = 1'b0;
    clear_chain();
    run_load(0, 0, 0);
    total_cnt++;
    if (r_err_first !== 1'b0) $display("FAIL error_clear_on_start: got %b expected 0", r_err_first);
    else pass_cnt++;
    total_cnt++;
    if (bus.error !== 1'b0) $display("FAIL intact_error: got %b expected 0", bus.error);
    else pass_cnt++;
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_in = 8'h00;
    for (int k = 0; k < 48; k++) exp_chain[383 - 8 * k -: 8] = 8'(k);
    test_reset();
    test_nominal();
    test_stall();
    test_abort();
    test_start_mid_load();
    test_async_reset();
`ifdef IO_CFG_READBACK_EN
    test_readback_stuck();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
